// File: rtl/rv32i_writeback_arbiter.sv
// Register-file write-port arbiter: merges ALU and long-latency results into one
// registered write per cycle, queues long-latency results and tracks pending destinations.
module rv32i_writeback_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [31:0]                   alu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_rd,
  input  logic [31:0]                   lsu_data,
  input  logic                          issue_valid,
  input  logic                          issue_long,
  input  logic [4:0]                    issue_rd,
  input  logic [4:0]                    rs1_addr,
  input  logic [4:0]                    rs2_addr,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic [4:0]                    rd_addr,
  output logic [31:0]                   rd_data,
  output logic                          rd_we,
  output logic [$clog2(FIFO_DEPTH):0]   pending_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    fifo_rd_mem   [FIFO_DEPTH];
  logic [31:0]   fifo_data_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;

  logic          rd_we_reg, lsu_src_reg;
  logic [4:0]    rd_addr_reg;
  logic [31:0]   rd_data_reg;
  logic [31:0]   busy_reg, set_vec, clr_vec;

  logic          fifo_empty, fifo_full, lsu_fire;
  logic          alu_sel, head_sel, bypass_sel, push, pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign lsu_ready  = !rst && !fifo_full;
  assign lsu_fire   = lsu_valid && lsu_ready;

  assign head_rd    = fifo_rd_mem[rd_ptr_reg];
  assign head_data  = fifo_data_mem[rd_ptr_reg];

  assign alu_sel    = alu_valid && (alu_rd != 5'd0);
  assign head_sel   = !alu_sel && !fifo_empty && (head_rd != 5'd0);
  assign bypass_sel = !alu_sel && fifo_empty && lsu_fire && (lsu_rd != 5'd0);
  // An x0 head never needs the write slot, so it drains even when the ALU wins.
  assign pop        = !fifo_empty && (!alu_sel || (head_rd == 5'd0));
  assign push       = lsu_fire && (lsu_rd != 5'd0) && !bypass_sel;

  always_comb begin
    count_next = count_reg + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg]   <= lsu_rd;
      fifo_data_mem[wr_ptr_reg] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_we_reg   <= 1'b0;
      lsu_src_reg <= 1'b0;
      rd_addr_reg <= 5'd0;
      rd_data_reg <= 32'd0;
    end else begin
      rd_we_reg   <= alu_sel || head_sel || bypass_sel;
      lsu_src_reg <= head_sel || bypass_sel;
      if (alu_sel) begin
        rd_addr_reg <= alu_rd;
        rd_data_reg <= alu_data;
      end else if (head_sel) begin
        rd_addr_reg <= head_rd;
        rd_data_reg <= head_data;
      end else if (bypass_sel) begin
        rd_addr_reg <= lsu_rd;
        rd_data_reg <= lsu_data;
      end
    end
  end

  // Clear follows the register file capturing an LSU-sourced write; set wins on collision.
  for (genvar gi = 0; gi < 32; gi++) begin : g_sb
    assign set_vec[gi] = issue_valid && issue_long && (issue_rd != 5'd0) && (issue_rd == 5'(gi));
    assign clr_vec[gi] = rd_we_reg && lsu_src_reg && (rd_addr_reg == 5'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= (busy_reg & ~clr_vec) | set_vec;
  end

  assign rs1_busy    = busy_reg[rs1_addr];
  assign rs2_busy    = busy_reg[rs2_addr];
  assign rd_we       = rd_we_reg;
  assign rd_addr     = rd_addr_reg;
  assign rd_data     = rd_data_reg;
  assign pending_cnt = count_reg;

endmodule

// File: tb/tb_rv32i_writeback_arbiter.sv
// Bench for rv32i_writeback_arbiter: directed sequences, a contention vector table,
// and randomized traffic against a queue-based reference model.
module tb_rv32i_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr, rd_addr;
  logic [31:0] alu_data, lsu_data, rd_data;
  logic        issue_valid, issue_long, rs1_busy, rs2_busy, rd_we;
  logic [1:0]  pending_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32i_writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we), .pending_cnt(pending_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    issue_valid = 1'b0; issue_long = 1'b0; issue_rd = 5'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
  endtask

  typedef struct {
    logic       alu_v;
    logic [4:0] alu_r;
    logic       lsu_v;
    logic [4:0] lsu_r;
    logic       exp_ready;
    logic       exp_we;
    logic [4:0] exp_addr;
    logic [1:0] exp_pend;
  } vec_t;

  vec_t vecs [8];

  // Reference model state
  logic [4:0]  q_rd   [$];
  logic [31:0] q_data [$];
  logic [31:0] m_busy;
  logic        m_we, m_src;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  initial begin
    logic [31:0] exp_d;
    logic        m_ready, fire, bypassed;

    // Contention on a depth-2 FIFO: ALU x1..x4 starve LSU x10..x12.
    vecs[0] = '{1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b1, 5'd1,  2'd1};
    vecs[1] = '{1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b1, 5'd2,  2'd2};
    vecs[2] = '{1'b1, 5'd3, 1'b1, 5'd12, 1'b0, 1'b1, 5'd3,  2'd2};
    vecs[3] = '{1'b1, 5'd4, 1'b1, 5'd12, 1'b0, 1'b1, 5'd4,  2'd2};
    vecs[4] = '{1'b0, 5'd0, 1'b1, 5'd12, 1'b0, 1'b1, 5'd10, 2'd1};
    vecs[5] = '{1'b0, 5'd0, 1'b1, 5'd12, 1'b1, 1'b1, 5'd11, 2'd1};
    vecs[6] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd12, 2'd0};
    vecs[7] = '{1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd12, 2'd0};

    // Reset held with traffic present
    idle_inputs();
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1111_1111;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h2222_2222;
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("reset rd_we", rd_we, 0);
      check("reset rd_addr", rd_addr, 0);
      check("reset rd_data", rd_data, 0);
      check("reset lsu_ready", lsu_ready, 0);
      check("reset pending_cnt", pending_cnt, 0);
      check("reset rs1_busy", rs1_busy, 0);
      $display("reset cycle %0d: rd_we=%0b lsu_ready=%0b pending=%0d", c, rd_we, lsu_ready, pending_cnt);
    end
    idle_inputs();
    rst = 1'b0;
    #1;
    check("lsu_ready after release", lsu_ready, 1);

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    check("alu rd_we", rd_we, 1);
    check("alu rd_addr", rd_addr, 5);
    check("alu rd_data", rd_data, 32'hDEAD_BEEF);
    $display("alu write: x%0d = 0x%08h", rd_addr, rd_data);
    tick();
    check("alu rd_we drops", rd_we, 0);

    // LSU bypass with scoreboard
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0; issue_long = 1'b0; issue_rd = 5'd0; rs1_addr = 5'd7;
    #1;
    check("x7 busy after issue", rs1_busy, 1);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234_5678;
    tick();
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    check("bypass rd_we", rd_we, 1);
    check("bypass rd_addr", rd_addr, 7);
    check("bypass rd_data", rd_data, 32'h1234_5678);
    check("bypass pending_cnt", pending_cnt, 0);
    check("x7 busy during write", rs1_busy, 1);
    $display("lsu bypass write: x%0d = 0x%08h", rd_addr, rd_data);
    tick();
    check("x7 busy cleared", rs1_busy, 0);
    check("bypass rd_we drops", rd_we, 0);

    // Contention vector table
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      alu_valid = vecs[i].alu_v; alu_rd = vecs[i].alu_r; alu_data = 32'h100 + 32'(vecs[i].alu_r);
      lsu_valid = vecs[i].lsu_v; lsu_rd = vecs[i].lsu_r; lsu_data = 32'hA000 + 32'(vecs[i].lsu_r);
      #1;
      check($sformatf("vec%0d lsu_ready", i), lsu_ready, vecs[i].exp_ready);
      tick();
      exp_d = (vecs[i].exp_addr < 5'd10) ? 32'h100 + 32'(vecs[i].exp_addr)
                                         : 32'hA000 + 32'(vecs[i].exp_addr);
      check($sformatf("vec%0d rd_we", i), rd_we, vecs[i].exp_we);
      check($sformatf("vec%0d rd_addr", i), rd_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d rd_data", i), rd_data, exp_d);
      check($sformatf("vec%0d pending_cnt", i), pending_cnt, vecs[i].exp_pend);
      $display("vec %0d: rd_we=%0b x%0d = 0x%08h pending=%0d", i, rd_we, rd_addr, rd_data, pending_cnt);
    end

    // x0 handling
    idle_inputs();
    alu_valid = 1'b1; lsu_valid = 1'b1; alu_data = 32'h5555; lsu_data = 32'h6666;
    issue_valid = 1'b1; issue_long = 1'b1;
    tick();
    idle_inputs();
    check("x0 rd_we", rd_we, 0);
    check("x0 pending_cnt", pending_cnt, 0);
    check("x0 rs1_busy", rs1_busy, 0);
    tick();
    check("x0 rd_we later", rd_we, 0);
    $display("x0 sequence: rd_we=%0b pending=%0d", rd_we, pending_cnt);

    // Reset mid-operation with two queued entries and x9 busy
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h20;
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0; issue_long = 1'b0; issue_rd = 5'd0;
    alu_rd = 5'd2; lsu_rd = 5'd21;
    tick();
    idle_inputs();
    rs2_addr = 5'd9;
    #1;
    check("midrst pending before", pending_cnt, 2);
    check("midrst x9 busy before", rs2_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst pending", pending_cnt, 0);
    check("midrst x9 busy", rs2_busy, 0);
    check("midrst rd_we", rd_we, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("midrst quiet%0d rd_we", c), rd_we, 0);
    end
    $display("mid-op reset: pending=%0d rs2_busy=%0b", pending_cnt, rs2_busy);

    // Randomized traffic against the queue model
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_rd.delete(); q_data.delete();
    m_busy = '0; m_we = 1'b0; m_src = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst         = ($urandom_range(0, 99) == 0);
      alu_valid   = ($urandom_range(0, 1) == 1);
      alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 1) == 1);
      lsu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lsu_data    = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_long  = ($urandom_range(0, 1) == 1);
      issue_rd    = 5'($urandom_range(0, 31));
      rs1_addr    = 5'($urandom_range(0, 31));
      rs2_addr    = 5'($urandom_range(0, 31));
      #1;
      m_ready = !rst && (q_rd.size() < DEPTH);
      check("rand lsu_ready", lsu_ready, m_ready);
      check("rand pending_cnt", pending_cnt, q_rd.size());
      check("rand rs1_busy", rs1_busy, (rs1_addr != 0) && m_busy[rs1_addr]);
      check("rand rs2_busy", rs2_busy, (rs2_addr != 0) && m_busy[rs2_addr]);

      if (rst) begin
        q_rd.delete(); q_data.delete();
        m_busy = '0; m_we = 1'b0; m_src = 1'b0; m_addr = 5'd0; m_data = 32'd0;
      end else begin
        if (m_we && m_src) m_busy[m_addr] = 1'b0;
        if (issue_valid && issue_long && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        fire = lsu_valid && m_ready;
        bypassed = 1'b0;
        m_we = 1'b0; m_src = 1'b0;
        if (alu_valid && alu_rd != 0) begin
          m_we = 1'b1; m_addr = alu_rd; m_data = alu_data;
        end else if (q_rd.size() > 0) begin
          m_we = 1'b1; m_src = 1'b1;
          m_addr = q_rd.pop_front(); m_data = q_data.pop_front();
        end else if (fire && lsu_rd != 0) begin
          m_we = 1'b1; m_src = 1'b1; m_addr = lsu_rd; m_data = lsu_data;
          bypassed = 1'b1;
        end
        if (fire && lsu_rd != 0 && !bypassed) begin
          q_rd.push_back(lsu_rd); q_data.push_back(lsu_data);
        end
      end

      tick();
      check("rand rd_we", rd_we, m_we);
      check("rand rd_addr", rd_addr, m_addr);
      check("rand rd_data", rd_data, m_data);
      if (rd_we) $display("rand %0d: x%0d = 0x%08h", cyc, rd_addr, rd_data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
